jtag_vdr_engine: RTL and testbench
==================================

Name: jtag_vdr_engine

Overview:
Parametrised virtual-DR engine that sits behind altera_jtag_sld_node's virtual-state outputs and replaces single-byte shifting with a word-framed streaming data path. It decodes the five SLD IR modes (DATA, LOOPBACK, DEBUG, INFO, CONTROL) and runs one mode-specific shift register per scan. In DATA mode it exchanges DATA_W-bit words with fabric through tx/rx handshakes.

Parameters:
DATA_W, 8, DATA-mode word width (2..32)
IR_W, 3, width of ir_in/ir_out
DBG_W, 8, DEBUG capture width
CTRL_W, 8, CONTROL register width
INFO_WORD, 32'h0001_0803, constant returned in INFO mode (32 bits)

Ports:
tck  in  1  JTAG clock; sole clock
reset  in  1  synchronous, active-high reset
ir_in  in  IR_W  virtual IR value
vs_cdr  in  1  virtual capture-DR
vs_sdr  in  1  virtual shift-DR
vs_e1dr  in  1  virtual exit1-DR
vs_udr  in  1  virtual update-DR
tdi  in  1  serial data in
tdo  out  1  serial data out
ir_out  out  IR_W  status: [0]=tx_valid, [1]=rx_ovf, others 0
tx_data  in  DATA_W  word to send to host
tx_valid  in  1  tx_data valid
tx_ready  out  1  one-cycle pop strobe for tx_data
rx_data  out  DATA_W  word received from host
rx_valid  out  1  one-cycle strobe, rx_data valid
rx_ready  in  1  fabric can accept rx word
dbg_in  in  DBG_W  DEBUG capture value
ctrl_out  out  CTRL_W  CONTROL register
ctrl_strobe  out  1  one-cycle pulse on ctrl_out update

Behaviour:
- Reset values: tdo=0, tx_ready=0, rx_valid=0, rx_data=0, ctrl_out=0, ctrl_strobe=0, rx_ovf=0, shift reg=0, bitcnt=0, mode=DATA.
- Mode encoding: 0 DATA, 1 LOOPBACK, 2 DEBUG, 3 INFO, 4 CONTROL, 5-7 BYPASS (1-bit register, captures 0).
- Mode is latched from ir_in on vs_cdr. ir_in changes during a scan are ignored until the next vs_cdr.
- Priority when strobes coincide: reset > vs_cdr > vs_sdr > vs_udr.
- tdo is combinational: sr[0] of the active mode register (LOOPBACK: the delay flop).
- Shift: LSB first. On each tck with vs_sdr: sr <= {tdi, sr[N-1:1]}. bitcnt saturates at 63.
- DATA, on vs_cdr:
  - bitcnt=0.
  - If tx_valid: sr<=tx_data and tx_ready pulses this cycle. Otherwise sr<=0.
- DATA, shift with bitcnt==DATA_W-1 (word complete):
  - If rx_ready: rx_data<={tdi,sr[DATA_W-1:1]} and rx_valid=1 on the next cycle. Otherwise the word is dropped and rx_ovf is set (sticky).
  - bitcnt wraps to 0 and sr reloads from tx_data/tx_ready as on vs_cdr.
- DATA, partial word at vs_e1dr: discarded, with no rx_valid and no tx_ready.
- LOOPBACK: one-flop delay, tdo = tdi registered on the previous shift.
- DEBUG: capture dbg_in, shift DBG_W bits. Extra bits shift in tdi.
- INFO: capture INFO_WORD. Shift circularly (MSB <= sr[0]), so reads longer than 32 bits repeat the word.
- CONTROL:
  - Capture ctrl_out and shift CTRL_W bits.
  - On vs_udr with bitcnt>=CTRL_W: ctrl_out<=sr[CTRL_W-1:0], ctrl_strobe pulses, rx_ovf clears.
  - With bitcnt<CTRL_W: no update.
- Reset mid-scan aborts the scan. No strobes are emitted.

Optional Feature:
JTAG_VDR_PARITY_EN
- Defined:
  - The DATA frame becomes DATA_W+1 bits; bit DATA_W is even parity.
  - Outbound: parity of the loaded tx word.
  - Inbound: the parity bit is checked. On mismatch the word is dropped, no rx_valid, and a sticky parity_err output (port present only under the macro) is set.
  - parity_err clears alongside rx_ovf.
  - ir_out[2] = parity_err.
- Undefined: DATA_W-bit frames, no parity logic, no parity_err port.

Decomposition:
- Package jtag_vdr_pkg: mode enum and IR encodings, INFO_WORD default, bitcnt width constant.
- One sub-module, jtag_vdr_framer: owns bitcnt, word-complete detection, tx load/tx_ready and the rx_valid/rx_ovf logic.

Test Plan:
- Reset, then ir_in=3, cdr, 32 shifts with tdi=0 -> tdo stream equals 32'h0001_0803 LSB first. Shifts 33-64 repeat the word.
- DATA, tx_valid with A5 then 3C, rx_ready=1, 16 shifts sending 11,22 -> tdo A5,3C. rx_valid twice, rx_data 11 then 22. Two tx_ready pulses.
- DATA, rx_ready=0, 8 shifts -> no rx_valid, ir_out[1]=1. CONTROL scan writing 0x5A -> ctrl_out=5A, ctrl_strobe 1 cycle, ir_out[1]=0.
- CONTROL, only 5 bits shifted then udr -> ctrl_out unchanged, no strobe.
- DATA, e1dr after 5 bits -> no rx_valid. ir_in changed mid-scan -> mode unchanged. Reset asserted mid-scan -> all outputs at reset values next cycle.
- With JTAG_VDR_PARITY_EN: send 0x07 with parity 0 (wrong) -> word dropped, parity_err=1. Send 0x07 with parity 1 -> rx_valid, rx_data=07.

Source files
------------

// File: rtl/jtag_vdr_pkg.sv
// jtag_vdr_pkg: mode encodings and shared constants for the virtual-DR engine.
// JTAG_VDR_PARITY_EN widens the DATA frame by one even-parity bit.
package jtag_vdr_pkg;

    typedef enum logic [2:0] {
        MODE_DATA   = 3'd0,
        MODE_LOOP   = 3'd1,
        MODE_DEBUG  = 3'd2,
        MODE_INFO   = 3'd3,
        MODE_CTRL   = 3'd4,
        MODE_BYPASS = 3'd5
    } mode_e;

    localparam logic [31:0] INFO_WORD_DEF = 32'h0001_0803;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef JTAG_VDR_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // Every IR value above CONTROL selects the 1-bit bypass register.
    function automatic mode_e ir_to_mode(input logic [31:0] ir);
        if (ir > 32'd4) return MODE_BYPASS;
        return mode_e'(ir[2:0]);
    endfunction

endpackage

// File: rtl/jtag_vdr_framer.sv
// jtag_vdr_framer: bit counter, DATA word framing, tx reload and rx delivery.
// With JTAG_VDR_PARITY_EN the frame carries an even-parity bit at the top.
module jtag_vdr_framer
    import jtag_vdr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              tck_i,
    input  logic              reset_i,
    input  logic              cdr_i,
    input  logic              cap_data_i,
    input  logic              shift_i,
    input  logic              e1_i,
    input  logic              data_mode_i,
    input  logic              tdi_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              rx_ovf_o,
`ifdef JTAG_VDR_PARITY_EN
    output logic              parity_err_o,
`endif
    output logic [CNT_W-1:0]  bitcnt_o,
    output logic              sr0_o
);

    localparam int FW = DATA_W + PAR_W;

    logic [FW-1:0]     sr_q;
    logic [FW-1:0]     tx_frame;
    logic [FW-1:0]     rx_word;
    logic [CNT_W-1:0]  bitcnt_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              ovf_q;
    logic              done;
    logic              load;
`ifdef JTAG_VDR_PARITY_EN
    logic              par_ok;
    logic              perr_q;
`endif

    // Word-complete detection and the frame to reload on capture or wrap.
    always_comb begin
        done    = shift_i && data_mode_i && (bitcnt_q == CNT_W'(FW - 1));
        load    = cap_data_i || done;
        rx_word = {tdi_i, sr_q[FW-1:1]};
`ifdef JTAG_VDR_PARITY_EN
        tx_frame = {^tx_data_i, tx_data_i};
        par_ok   = ~^rx_word;
`else
        tx_frame = tx_data_i;
`endif
        tx_ready_o = !reset_i && load && tx_valid_i;
    end

    // Counter, data shift register and sticky rx status.
    always_ff @(posedge tck_i) begin
        if (reset_i) begin
            sr_q       <= '0;
            bitcnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef JTAG_VDR_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            if (cdr_i || done || (e1_i && data_mode_i)) begin
                bitcnt_q <= '0;
            end else if (shift_i && (bitcnt_q != CNT_MAX)) begin
                bitcnt_q <= bitcnt_q + CNT_W'(1);
            end
            if (load) begin
                sr_q <= tx_valid_i ? tx_frame : '0;
            end else if (shift_i && data_mode_i) begin
                sr_q <= rx_word;
            end
            if (clr_i) begin
                ovf_q  <= 1'b0;
`ifdef JTAG_VDR_PARITY_EN
                perr_q <= 1'b0;
`endif
            end
            if (done) begin
`ifdef JTAG_VDR_PARITY_EN
                if (!par_ok) begin
                    perr_q <= 1'b1;
                end else
`endif
                if (rx_ready_i) begin
                    rx_data_q  <= rx_word[DATA_W-1:0];
                    rx_valid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_ovf_o   = ovf_q;
    assign bitcnt_o   = bitcnt_q;
    assign sr0_o      = sr_q[0];
`ifdef JTAG_VDR_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: rtl/jtag_vdr_engine.sv
// jtag_vdr_engine: SLD virtual-DR engine with per-mode scan registers.
// Define JTAG_VDR_PARITY_EN for parity-framed DATA words and parity_err.
module jtag_vdr_engine
    import jtag_vdr_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          IR_W      = 3,
    parameter int          DBG_W     = 8,
    parameter int          CTRL_W    = 8,
    parameter logic [31:0] INFO_WORD = INFO_WORD_DEF
) (
    input  logic              tck,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              vs_cdr,
    input  logic              vs_sdr,
    input  logic              vs_e1dr,
    input  logic              vs_udr,
    input  logic              tdi,
    output logic              tdo,
    output logic [IR_W-1:0]   ir_out,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DBG_W-1:0]  dbg_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_strobe
`ifdef JTAG_VDR_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    mode_e             mode_q;
    mode_e             cap_mode;
    logic              cdr;
    logic              sdr;
    logic              e1;
    logic              udr;
    logic              ctrl_upd;
    logic              loop_q;
    logic              byp_q;
    logic [DBG_W-1:0]  dbg_q;
    logic [31:0]       info_q;
    logic [CTRL_W-1:0] csr_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              strobe_q;
    logic [CNT_W-1:0]  bitcnt;
    logic              data_sr0;
    logic              rx_ovf;
`ifdef JTAG_VDR_PARITY_EN
    logic              perr;
`endif

    // Strobe priority cdr > sdr > udr and capture-time mode decode.
    always_comb begin
        cap_mode = ir_to_mode(32'(ir_in));
        cdr      = vs_cdr;
        sdr      = vs_sdr && !vs_cdr;
        e1       = vs_e1dr && !vs_cdr && !vs_sdr;
        udr      = vs_udr && !vs_cdr && !vs_sdr;
        ctrl_upd = udr && (mode_q == MODE_CTRL)
                   && (32'(bitcnt) >= CTRL_W);
    end

    jtag_vdr_framer #(
        .DATA_W (DATA_W)
    ) u_framer (
        .tck_i        (tck),
        .reset_i      (reset),
        .cdr_i        (cdr),
        .cap_data_i   (cdr && (cap_mode == MODE_DATA)),
        .shift_i      (sdr),
        .e1_i         (e1),
        .data_mode_i  (mode_q == MODE_DATA),
        .tdi_i        (tdi),
        .clr_i        (ctrl_upd),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .rx_ovf_o     (rx_ovf),
`ifdef JTAG_VDR_PARITY_EN
        .parity_err_o (perr),
`endif
        .bitcnt_o     (bitcnt),
        .sr0_o        (data_sr0)
    );

    // Mode latch plus capture/shift of the non-DATA scan registers.
    always_ff @(posedge tck) begin
        if (reset) begin
            mode_q <= MODE_DATA;
            loop_q <= 1'b0;
            byp_q  <= 1'b0;
            dbg_q  <= '0;
            info_q <= '0;
            csr_q  <= '0;
        end else if (cdr) begin
            mode_q <= cap_mode;
            unique case (cap_mode)
                MODE_LOOP:   loop_q <= 1'b0;
                MODE_DEBUG:  dbg_q  <= dbg_in;
                MODE_INFO:   info_q <= INFO_WORD;
                MODE_CTRL:   csr_q  <= ctrl_q;
                MODE_BYPASS: byp_q  <= 1'b0;
                default: ;
            endcase
        end else if (sdr) begin
            unique case (mode_q)
                MODE_LOOP:   loop_q <= tdi;
                MODE_DEBUG:  dbg_q  <= {tdi, dbg_q[DBG_W-1:1]};
                MODE_INFO:   info_q <= {info_q[0], info_q[31:1]};
                MODE_CTRL:   csr_q  <= {tdi, csr_q[CTRL_W-1:1]};
                MODE_BYPASS: byp_q  <= tdi;
                default: ;
            endcase
        end
    end

    // CONTROL commit: a full-length scan updates ctrl_out and pulses the strobe.
    always_ff @(posedge tck) begin
        if (reset) begin
            ctrl_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= ctrl_upd;
            if (ctrl_upd) begin
                ctrl_q <= csr_q;
            end
        end
    end

    // Serial output of the active register and the IR status word.
    always_comb begin
        tdo = 1'b0;
        unique case (mode_q)
            MODE_DATA:   tdo = data_sr0;
            MODE_LOOP:   tdo = loop_q;
            MODE_DEBUG:  tdo = dbg_q[0];
            MODE_INFO:   tdo = info_q[0];
            MODE_CTRL:   tdo = csr_q[0];
            MODE_BYPASS: tdo = byp_q;
            default:     tdo = 1'b0;
        endcase
        ir_out    = '0;
        ir_out[0] = tx_valid;
        ir_out[1] = rx_ovf;
`ifdef JTAG_VDR_PARITY_EN
        ir_out[2] = perr;
`endif
    end

    assign ctrl_out    = ctrl_q;
    assign ctrl_strobe = strobe_q;
`ifdef JTAG_VDR_PARITY_EN
    assign parity_err  = perr;
`endif

endmodule

// File: tb/tb_jtag_vdr_engine.sv
// tb_jtag_vdr_engine: directed scans against jtag_vdr_engine, default parameters.
// Define JTAG_VDR_PARITY_EN to also cover the parity-framed DATA path.
module tb_jtag_vdr_engine;
    import jtag_vdr_pkg::*;

    localparam int FW = 8 + PAR_W;

    logic       tck = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] ir_in = '0;
    logic       vs_cdr = 1'b0;
    logic       vs_sdr = 1'b0;
    logic       vs_e1dr = 1'b0;
    logic       vs_udr = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [2:0] ir_out;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] dbg_in = '0;
    logic [7:0] ctrl_out;
    logic       ctrl_strobe;
`ifdef JTAG_VDR_PARITY_EN
    logic       parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_txr = 0;
    int n_rxv = 0;
    logic [7:0] rxq[$];

    jtag_vdr_engine dut (
        .tck         (tck),
        .reset       (reset),
        .ir_in       (ir_in),
        .vs_cdr      (vs_cdr),
        .vs_sdr      (vs_sdr),
        .vs_e1dr     (vs_e1dr),
        .vs_udr      (vs_udr),
        .tdi         (tdi),
        .tdo         (tdo),
        .ir_out      (ir_out),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .dbg_in      (dbg_in),
        .ctrl_out    (ctrl_out),
        .ctrl_strobe (ctrl_strobe)
`ifdef JTAG_VDR_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 tck = ~tck;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] frame(input logic [7:0] v);
`ifdef JTAG_VDR_PARITY_EN
        return {55'd0, ^v, v};
`else
        return {56'd0, v};
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic capture(input logic [2:0] ir);
        ir_in  = ir;
        vs_cdr = 1'b1;
        #1;
        if (tx_ready) n_txr++;
        tick();
        vs_cdr = 1'b0;
    endtask

    task automatic shift(input int n, input logic [63:0] din,
                         output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            vs_sdr = 1'b1;
            tdi    = din[i];
            #1;
            dout[i] = tdo;
            if (tx_ready) n_txr++;
            tick();
            if (rx_valid) begin
                n_rxv++;
                rxq.push_back(rx_data);
            end
        end
        vs_sdr = 1'b0;
    endtask

    initial begin
        logic [63:0] got;
        logic [15:0] pair;

        tick();
        tick();
        chk("rst_tdo", tdo, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_ctrl_out", ctrl_out, 0);
        chk("rst_ctrl_strobe", ctrl_strobe, 0);
        chk("rst_ir_out", ir_out, 0);
`ifdef JTAG_VDR_PARITY_EN
        chk("rst_parity_err", parity_err, 0);
`endif
        reset = 1'b0;

        capture(3'd3);
        shift(64, 64'd0, got);
        chk("info_tdo64", got, 64'h0001_0803_0001_0803);

        dbg_in = 8'hC6;
        capture(3'd2);
        shift(10, 64'h0A5, got);
        chk("debug_tdo", got, 64'h1C6);

        capture(3'd1);
        shift(4, 64'hB, got);
        chk("loop_tdo", got, 64'h6);

        capture(3'd6);
        shift(3, 64'h5, got);
        chk("bypass_tdo", got, 64'h2);

        rx_ready = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        #1;
        chk("irout_txv", ir_out, 3'b001);
        n_txr = 0;
        n_rxv = 0;
        rxq.delete();
        capture(3'd0);
        tx_data = 8'h3C;
        shift(FW, frame(8'h11), got);
        chk("data_tdo_w0", got, frame(8'hA5));
        tx_valid = 1'b0;
        shift(FW, frame(8'h22), got);
        chk("data_tdo_w1", got, frame(8'h3C));
        chk("data_txr_cnt", n_txr, 2);
        chk("data_rxv_cnt", n_rxv, 2);
        pair = {(rxq.size() > 1) ? rxq[1] : 8'h00,
                (rxq.size() > 0) ? rxq[0] : 8'h00};
        chk("data_rx_words", pair, 16'h2211);

        rx_ready = 1'b0;
        n_rxv = 0;
        capture(3'd0);
        shift(FW, frame(8'h99), got);
        chk("ovf_no_rxv", n_rxv, 0);
        chk("ovf_irout", ir_out, 3'b010);

        capture(3'd4);
        shift(8, 64'h5A, got);
        chk("ctrl_cap_old", got, 0);
        vs_e1dr = 1'b1;
        tick();
        vs_e1dr = 1'b0;
        chk("ctrl_pre_strobe", ctrl_strobe, 0);
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        chk("ctrl_out_5a", ctrl_out, 8'h5A);
        chk("ctrl_strobe_hi", ctrl_strobe, 1);
        chk("ctrl_clr_ovf", ir_out, 3'b000);
        tick();
        chk("ctrl_strobe_lo", ctrl_strobe, 0);

        capture(3'd4);
        shift(5, 64'h1F, got);
        chk("ctrl_short_cap", got, 64'h1A);
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        chk("ctrl_short_out", ctrl_out, 8'h5A);
        chk("ctrl_short_strobe", ctrl_strobe, 0);

        rx_ready = 1'b1;
        n_rxv = 0;
        capture(3'd0);
        shift(5, 64'h1F, got);
        vs_e1dr = 1'b1;
        tick();
        vs_e1dr = 1'b0;
        if (rx_valid) n_rxv++;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        if (rx_valid) n_rxv++;
        chk("e1_no_rxv", n_rxv, 0);
        chk("e1_rx_data_kept", rx_data, 8'h22);

        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        n_txr = 0;
        capture(3'd3);
        ir_in = 3'd0;
        shift(16, 64'd0, got);
        chk("irchg_tdo", got, 64'h0803);
        chk("irchg_no_txr", n_txr, 0);

        tx_data = 8'hC3;
        n_txr = 0;
        capture(3'd0);
        chk("mid_cap_txr", n_txr, 1);
        shift(FW - 1, 64'd0, got);
        reset  = 1'b1;
        vs_sdr = 1'b1;
        tdi    = 1'b1;
        #1;
        chk("mid_txr_gated", tx_ready, 0);
        tick();
        reset  = 1'b0;
        vs_sdr = 1'b0;
        #1;
        chk("mid_tdo", tdo, 0);
        chk("mid_tx_ready", tx_ready, 0);
        chk("mid_rx_valid", rx_valid, 0);
        chk("mid_rx_data", rx_data, 0);
        chk("mid_ctrl_out", ctrl_out, 0);
        chk("mid_ctrl_strobe", ctrl_strobe, 0);
        chk("mid_ir_out", ir_out, 3'b001);

`ifdef JTAG_VDR_PARITY_EN
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        n_rxv = 0;
        capture(3'd0);
        shift(FW, {55'd0, 1'b0, 8'h07}, got);
        chk("par_bad_no_rxv", n_rxv, 0);
        chk("par_bad_err", parity_err, 1);
        chk("par_bad_irout", ir_out, 3'b100);
        shift(FW, {55'd0, 1'b1, 8'h07}, got);
        chk("par_ok_rxv", n_rxv, 1);
        chk("par_ok_rx_data", rx_data, 8'h07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
